// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU control sequencer.
// Holds the FSM state type, ALUOp class codes, Funct7 patterns and
// the full 5-bit Operation code map (base ALU/branch ops plus RV32M ops).
package alu_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] ALUOP_MEM = 2'b00;  // LW/SW/AUIPC
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branches
  localparam logic [1:0] ALUOP_RI  = 2'b10;  // R/I-type arithmetic
  localparam logic [1:0] ALUOP_JL  = 2'b11;  // JAL/LUI

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_XOR    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_AND    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b00110;
  localparam logic [4:0] OP_SRL    = 5'b00111;
  localparam logic [4:0] OP_SLL    = 5'b01000;
  localparam logic [4:0] OP_BNE    = 5'b01010;
  localparam logic [4:0] OP_BLT    = 5'b01011;
  localparam logic [4:0] OP_BGE    = 5'b01100;
  localparam logic [4:0] OP_BEQ    = 5'b01101;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode request / result bus of the ALU control sequencer.
//   in_valid/in_ready + ALUOp/Funct7/Funct3 : decode request
//   out_valid/out_ready + Operation/illegal  : decoded result
//   busy, mc_start                           : multi-cycle status to pipeline / mul-div unit
// master = requester/consumer side, slave = sequencer side.
interface alu_ctrl_seq_if #(
  parameter int unsigned OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] Operation;
  logic            illegal;
  logic            busy;
  logic            mc_start;

  modport master (
    output in_valid, ALUOp, Funct7, Funct3, out_ready,
    input  in_ready, out_valid, Operation, illegal, busy, mc_start
  );

  modport slave (
    input  in_valid, ALUOp, Funct7, Funct3, out_ready,
    output in_ready, out_valid, Operation, illegal, busy, mc_start
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct3/Funct7 -> Operation decoder.
// Ports: alu_op, funct3, funct7 in; op (OP_W), illegal, is_mul, is_div out.
// Undefined combinations decode to op=0 with illegal=1; RV32M ops are
// illegal when M_EXT=0.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W  = 5,
  parameter bit          M_EXT = 1'b1
) (
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [OP_W-1:0] op,
  output logic            illegal,
  output logic            is_mul,
  output logic            is_div
);

  logic [4:0] op_full;
  logic       bad;

  always_comb begin
    op_full = OP_ADD;
    bad     = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (alu_op)
      ALUOP_MEM, ALUOP_JL: op_full = OP_ADD;
      ALUOP_BR: begin
        case (funct3)
          3'b000:  op_full = OP_BEQ;
          3'b001:  op_full = OP_BNE;
          3'b100:  op_full = OP_BLT;
          3'b101:  op_full = OP_BGE;
          default: bad = 1'b1;
        endcase
      end
      ALUOP_RI: begin
        if (funct7 == FUNCT7_MEXT) begin
          if (M_EXT) begin
            // M op codes are OP_MUL with Funct3 in the low bits; Funct3[2] splits mul/div.
            op_full = OP_MUL | {2'b00, funct3};
            is_mul  = !funct3[2];
            is_div  = funct3[2];
          end else begin
            bad = 1'b1;
          end
        end else if (funct7 == FUNCT7_BASE) begin
          case (funct3)
            3'b000:  op_full = OP_ADD;
            3'b001:  op_full = OP_SLL;
            3'b010:  op_full = OP_SLT;
            3'b100:  op_full = OP_XOR;
            3'b101:  op_full = OP_SRL;
            3'b110:  op_full = OP_OR;
            3'b111:  op_full = OP_AND;
            default: bad = 1'b1;
          endcase
        end else if (funct7 == FUNCT7_ALT) begin
          case (funct3)
            3'b000:  op_full = OP_SUB;
            3'b101:  op_full = OP_SRA;
            default: bad = 1'b1;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
    endcase
    if (bad) op_full = OP_ADD;
  end

  assign op      = op_full[OP_W-1:0];
  assign illegal = bad;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the decoded Operation behind a
// valid/ready handshake with a single output buffer, and sequences
// multi-cycle RV32M ops with a latency counter.
// Ports: clk, reset (sync, active-high), flush (drop in-flight op),
//        bus (alu_ctrl_seq_if.slave): request, result, busy, mc_start.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 5,
  parameter bit          M_EXT   = 1'b1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  alu_ctrl_seq_if.slave  bus
);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            mc_start_q, mc_start_d;

  logic [OP_W-1:0] dec_op;
  logic            dec_illegal, dec_mul, dec_div;
  logic            accept;

  alu_op_decode #(
    .OP_W  (OP_W),
    .M_EXT (M_EXT)
  ) u_dec (
    .alu_op  (bus.ALUOp),
    .funct3  (bus.Funct3),
    .funct7  (bus.Funct7),
    .op      (dec_op),
    .illegal (dec_illegal),
    .is_mul  (dec_mul),
    .is_div  (dec_div)
  );

  // A held result blocks acceptance; when the consumer takes it this cycle
  // the next request is accepted on the same edge.
  assign bus.in_ready = !reset && !flush && !busy_q && !(out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    mc_start_d  = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
      // Acceptance overrides the DONE->IDLE return for back-to-back ops.
      if (accept) begin
        op_d      = dec_op;
        illegal_d = dec_illegal;
        if (dec_mul || dec_div) begin
          state_d     = BUSY;
          busy_d      = 1'b1;
          mc_start_d  = 1'b1;
          out_valid_d = 1'b0;
          cnt_d       = dec_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        end else begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mc_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      mc_start_q  <= mc_start_d;
    end
  end

  assign bus.Operation = op_q;
  assign bus.illegal   = illegal_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.mc_start  = mc_start_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (M_EXT=1 instance plus an
// M_EXT=0 / OP_W=4 instance for the disabled-extension case).
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.OP_W(5)) bus ();
  alu_ctrl_seq_if #(.OP_W(4)) bus_nm ();

  alu_ctrl_seq #(.OP_W(5), .M_EXT(1'b1), .MUL_LAT(3), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  alu_ctrl_seq #(.OP_W(4), .M_EXT(1'b0), .MUL_LAT(3), .DIV_LAT(32)) dut_nm (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_nm)
  );

  task automatic set_req(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
    bus.in_valid = 1'b1;
    bus.ALUOp    = a;
    bus.Funct3   = f3;
    bus.Funct7   = f7;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.Funct3 = 3'b000; bus.Funct7 = 7'h00; bus.out_ready = 1'b0;
    bus_nm.in_valid = 1'b0; bus_nm.ALUOp = 2'b00; bus_nm.Funct3 = 3'b000; bus_nm.Funct7 = 7'h00; bus_nm.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.Operation !== 5'b00000) begin errors++; $display("FAIL rst_operation: got %b want 00000", bus.Operation); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", bus.illegal); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mc_start !== 1'b0) begin errors++; $display("FAIL rst_mc_start: got %b want 0", bus.mc_start); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_during: got %b want 0", bus.in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_sub();
    bus.out_ready = 1'b1;
    set_req(2'b10, 3'b000, 7'b0100000);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sub_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sub_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.Operation !== 5'b00001) begin errors++; $display("FAIL sub_operation: got %b want 00001", bus.Operation); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sub_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mc_start !== 1'b0) begin errors++; $display("FAIL sub_mc_start: got %b want 0", bus.mc_start); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sub_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_mul();
    bus.out_ready = 1'b0;
    set_req(2'b10, 3'b000, 7'b0000001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy[%0d]: got %b want 1", i, bus.busy); end
      checks++; if (bus.mc_start !== (i == 0)) begin errors++; $display("FAIL mul_mc_start[%0d]: got %b want %b", i, bus.mc_start, (i == 0)); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_out_valid_early[%0d]: got %b want 0", i, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      checks++; if (bus.Operation !== 5'b10000) begin errors++; $display("FAIL mul_operation[%0d]: got %b want 10000", i, bus.Operation); end
      @(negedge clk);
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mul_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.mc_start !== 1'b0) begin errors++; $display("FAIL mul_mc_start_end: got %b want 0", bus.mc_start); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mul_out_valid_hold: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush_div();
    int bad;
    bus.out_ready = 1'b1;
    set_req(2'b10, 3'b101, 7'b0000001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bad = 0;
    repeat (14) begin
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL divu_busy_window: got %0d bad cycles want 0", bad); end
    flush = 1'b1;
    set_req(2'b10, 3'b100, 7'b0000000);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.mc_start !== 1'b0) begin errors++; $display("FAIL flush_mc_start: got %b want 0", bus.mc_start); end
    checks++; if (bus.Operation !== 5'b10101) begin errors++; $display("FAIL flush_operation_hold: got %b want 10101", bus.Operation); end
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_after: got %b want 1", bus.in_ready); end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_no_result: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    set_req(2'b10, 3'b010, 7'b0000000);
    @(negedge clk);
    set_req(2'b01, 3'b001, 7'b0000000);
    checks++; if (bus.Operation !== 5'b00101) begin errors++; $display("FAIL stall_slt_op: got %b want 00101", bus.Operation); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_slt_valid: got %b want 1", bus.out_valid); end
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.Operation !== 5'b00101) begin errors++; $display("FAIL stall_hold_op[%0d]: got %b want 00101", i, bus.Operation); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.Operation !== 5'b01010) begin errors++; $display("FAIL stall_bne_op: got %b want 01010", bus.Operation); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_bne_valid: got %b want 1", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", bus.out_valid); end
  endtask

  // {ALUOp, Funct3, Funct7, expected Operation, expected illegal}
  logic [17:0] b2b_vec [13] = '{
    {2'b10, 3'b111, 7'h00, 5'b00100, 1'b0},  // and
    {2'b10, 3'b110, 7'h00, 5'b00011, 1'b0},  // or
    {2'b10, 3'b101, 7'h20, 5'b00110, 1'b0},  // srai
    {2'b10, 3'b101, 7'h00, 5'b00111, 1'b0},  // srli
    {2'b10, 3'b001, 7'h00, 5'b01000, 1'b0},  // slli
    {2'b10, 3'b100, 7'h00, 5'b00010, 1'b0},  // xor
    {2'b01, 3'b000, 7'h55, 5'b01101, 1'b0},  // beq
    {2'b01, 3'b110, 7'h00, 5'b00000, 1'b1},  // branch f3=110
    {2'b01, 3'b100, 7'h00, 5'b01011, 1'b0},  // blt
    {2'b10, 3'b011, 7'h00, 5'b00000, 1'b1},  // f3=011
    {2'b01, 3'b101, 7'h00, 5'b01100, 1'b0},  // bge
    {2'b10, 3'b001, 7'h20, 5'b00000, 1'b1},  // alt f7 on sll
    {2'b00, 3'b111, 7'h7f, 5'b00000, 1'b0}   // lw: add regardless of funct
  };

  task automatic test_back_to_back();
    logic [17:0] v;
    bus.out_ready = 1'b1;
    v = b2b_vec[0];
    set_req(v[17:16], v[15:13], v[12:6]);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i + 1 < 13) begin
        v = b2b_vec[i+1];
        set_req(v[17:16], v[15:13], v[12:6]);
      end else begin
        bus.in_valid = 1'b0;
      end
      v = b2b_vec[i];
      checks++; if (bus.Operation !== v[5:1]) begin errors++; $display("FAIL b2b_op[%0d]: got %b want %b", i, bus.Operation, v[5:1]); end
      checks++; if (bus.illegal !== v[0]) begin errors++; $display("FAIL b2b_illegal[%0d]: got %b want %b", i, bus.illegal, v[0]); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid); end
    end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_no_mext();
    bus_nm.out_ready = 1'b1;
    bus_nm.in_valid = 1'b1; bus_nm.ALUOp = 2'b10; bus_nm.Funct3 = 3'b000; bus_nm.Funct7 = 7'b0100000;
    @(negedge clk);
    bus_nm.Funct7 = 7'b0000001;
    checks++; if (bus_nm.Operation !== 4'b0001) begin errors++; $display("FAIL nm_sub_op: got %b want 0001", bus_nm.Operation); end
    @(negedge clk);
    bus_nm.in_valid = 1'b0;
    checks++; if (bus_nm.illegal !== 1'b1) begin errors++; $display("FAIL nm_mul_illegal: got %b want 1", bus_nm.illegal); end
    checks++; if (bus_nm.Operation !== 4'b0000) begin errors++; $display("FAIL nm_mul_op: got %b want 0000", bus_nm.Operation); end
    checks++; if (bus_nm.busy !== 1'b0) begin errors++; $display("FAIL nm_mul_busy: got %b want 0", bus_nm.busy); end
    checks++; if (bus_nm.mc_start !== 1'b0) begin errors++; $display("FAIL nm_mul_mc_start: got %b want 0", bus_nm.mc_start); end
    checks++; if (bus_nm.out_valid !== 1'b1) begin errors++; $display("FAIL nm_mul_valid: got %b want 1", bus_nm.out_valid); end
    @(negedge clk);
    checks++; if (bus_nm.busy !== 1'b0) begin errors++; $display("FAIL nm_mul_busy_after: got %b want 0", bus_nm.busy); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.out_ready = 1'b1;
    set_req(2'b10, 3'b100, 7'b0000001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_div_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.Operation !== 5'b00000) begin errors++; $display("FAIL rmid_op: got %b want 00000", bus.Operation); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", bus.in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready_after: got %b want 1", bus.in_ready); end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_result: got %0d bad cycles want 0", bad); end
    bus.out_ready = 1'b0;
    set_req(2'b10, 3'b010, 7'b0000000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rdone_valid_before: got %b want 1", bus.out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rdone_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.Operation !== 5'b00000) begin errors++; $display("FAIL rdone_op: got %b want 00000", bus.Operation); end
    bus.out_ready = 1'b1;
    set_req(2'b10, 3'b100, 7'b0000000);
    @(negedge clk);
    set_req(2'b11, 3'b011, 7'h7f);
    checks++; if (bus.Operation !== 5'b00010) begin errors++; $display("FAIL rdone_xor_op: got %b want 00010", bus.Operation); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.Operation !== 5'b00000) begin errors++; $display("FAIL jl_op: got %b want 00000", bus.Operation); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL jl_illegal: got %b want 0", bus.illegal); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL jl_valid: got %b want 1", bus.out_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_sub();
    test_mul();
    test_flush_div();
    test_stall();
    test_back_to_back();
    test_no_mext();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised successor to the combinational ALU-operation decoder.
- Decodes ALUOp/Funct3/Funct7 into a registered Operation code through a valid/ready handshake, with one output buffer.
- Adds RV32M (mul/div/rem) decode and sequences these multi-cycle ops with an internal latency counter, a busy/stall indication and flush.
- Sits between the ID/EX pipeline register and the ALU/multiplier-divider in the execute stage.

Parameters:
- OP_W, 5, Operation width; must be 5 when M_EXT=1, may be 4 when M_EXT=0.
- M_EXT, 1, 1 decodes RV32M ops; 0 flags them illegal.
- MUL_LAT, 3, execute cycles for mul/mulh/mulhsu/mulhu; must be >=1.
- DIV_LAT, 32, execute cycles for div/divu/rem/remu; must be >=1.
- CNT_W, $clog2(DIV_LAT+1), latency counter width; derived.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard in-flight op (branch mispredict/trap).
- in_valid  input  1  decode request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at clock edge.
- ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
- Funct7  input  7  instr[31:25].
- Funct3  input  3  instr[14:12].
- out_valid  output  1  Operation result complete.
- out_ready  input  1  consumer takes result.
- Operation  output  OP_W  registered ALU operation code.
- illegal  output  1  registered; the accepted combination is undefined.
- busy  output  1  multi-cycle op executing; stall upstream.
- mc_start  output  1  one-cycle pulse to the mul/div unit.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset puts state in IDLE and clears counter, Operation, out_valid, illegal, busy and mc_start to 0.
- in_ready is 0 when any of reset, flush or busy is 1, and when out_valid && !out_ready.
- Encoding, upper bit 0: add/lw/sw/auipc/jal/lui 0000, sub 0001, xor 0010, or 0011, and 0100, slt/slti 0101, srai 0110, srli 0111, slli 1000, bne 1010, blt 1011, bge 1100, beq 1101.
- Encoding, M ops (Funct7=0000001, ALUOp=10), Funct3 selects: mul 10000, mulh 10001, mulhsu 10010, mulhu 10011, div 10100, divu 10101, rem 10110, remu 10111.
- ALUOp=00 or 11 decodes as add, regardless of funct fields.
- Illegal: any other combination, including Funct3 011, branch Funct3 110/111, and M ops with M_EXT=0. An illegal op yields Operation=0 and illegal=1, and is treated as single-cycle.
- Acceptance edge (E0) always loads Operation and illegal. Operation then holds stable until the next acceptance.
- Single-cycle op: state goes to DONE; out_valid=1 from E0+1 cycle onward.
- Multi-cycle op:
  - State goes to BUSY; counter loads LAT (MUL_LAT or DIV_LAT).
  - mc_start=1 for exactly the cycle after E0.
  - busy=1 for exactly LAT cycles after E0.
  - Counter decrements each BUSY cycle. The edge at which it reaches 0 moves to DONE; out_valid=1 from edge E0+LAT.
- DONE: out_valid holds until out_ready=1.
  - out_ready && !in_valid: return to IDLE.
  - out_ready && in_valid: accept the next op in the same cycle (back-to-back, no bubble).
- out_valid=1 with out_ready=0: no acceptance; Operation and illegal hold.
- flush (any state): next edge forces IDLE and clears out_valid, busy, mc_start and counter. Operation and illegal hold their values. flush beats a simultaneous in_valid, which is not accepted.
- reset beats flush.
- Reset mid-BUSY: counter cleared, no out_valid pulse.
- Inputs are sampled only at acceptance; changes during BUSY/DONE are ignored.

Decomposition:
- alu_ctrl_pkg holds:
  - typedef enum state_t {IDLE, BUSY, DONE}.
  - ALUOp constants (ALUOP_MEM, ALUOP_BR, ALUOP_RI, ALUOP_JL).
  - All Operation code localparams (OP_ADD … OP_REMU).
  - FUNCT7_BASE=0000000, FUNCT7_ALT=0100000, FUNCT7_MEXT=0000001.
- Sub-module alu_op_decode: purely combinational mapping ALUOp/Funct3/Funct7 to {op, illegal, is_mul, is_div}, parametrised by M_EXT. The FSM, counter and handshake live in alu_ctrl_seq.

Test Plan:
- ALUOp=10, F3=000, F7=0100000, in_valid=1 at edge 1, out_ready=1 -> Operation=00001, out_valid=1 from edge 2, busy never 1.
- ALUOp=10, F3=000, F7=0000001 (mul), MUL_LAT=3, accepted at edge 10 -> mc_start=1 only during cycle 11, busy=1 cycles 11–13, Operation=10000, out_valid from edge 13, in_ready=0 throughout.
- divu (F3=101, F7=0000001) accepted at edge 5, DIV_LAT=32, flush=1 at edge 20 -> busy=0 and out_valid=0 after edge 20, out_valid never asserted, in_ready=1 at cycle 21.
- out_ready held 0 after slt (F3=010) completes, then new in_valid with bne -> in_ready=0, Operation stays 00101 for 4 cycles. Then out_ready=1 -> bne accepted that edge, Operation=01010.
- ALUOp=01, F3=110 -> illegal=1, Operation=0. With M_EXT=0, mul request -> illegal=1, busy never 1.
- reset asserted during BUSY of div and during DONE -> next cycle: all outputs 0, in_ready=1 once reset deasserts. ALUOp=11 then decodes to Operation=0, illegal=0.
